except_ctrl: RTL

Registered, parametrised exception/interrupt controller for the MIPS commit stage. It is the successor of the combinational exception resolver. It adds:
- a configurable number of external interrupt lines, with synchronisers and pending tracking;
- a latched timer interrupt;
- a one-cycle registered flush pulse, followed by a hold-off window that blocks re-entry while CP0 state (EXL/EPC) settles.

It sits between the memory/commit stage and the CP0 write port. Its `Except_request_t` output drives pipeline flush and PC redirect.

---
 rtl/except_ctrl.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/except_ctrl.sv
// MIPS commit-stage exception/interrupt controller: the flush request appears 1 cycle after accept.
// Stall or the post-flush hold-off defers acceptance, and interrupts stay pending in IP.
package except_ctrl_pkg;

   typedef struct packed {
      logic inst_adel;
      logic inst_tlb_miss;
      logic inst_tlb_invalid;
      logic syscall;
      logic brk;
      logic overflow;
      logic trap;
      logic eret;
      logic cpu;
      logic ri;
      logic priv_inst;
      logic data_adel;
      logic data_tlb_miss;
      logic data_addr_invalid;
      logic data_mod;
   } Except_info_t;

   typedef struct packed {
      logic       bev;
      logic [7:0] im;
      logic       erl;
      logic       exl;
      logic       ie;
   } cp0_status_t;

   typedef struct packed {
      logic       iv;
      logic [7:0] ip;
   } cp0_cause_t;

   typedef struct packed {
      cp0_status_t status;
      cp0_cause_t  cause;
      logic [31:0] epc;
      logic [31:0] error_epc;
      logic [31:0] ebase;
   } CP0_regs_t;

   typedef struct packed {
      logic        flush;
      logic [4:0]  code;
      logic        eret;
      logic        delayslot;
      logic [31:0] current_pc;
      logic [31:0] jump_pc;
      logic [31:0] extra;
   } Except_request_t;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_MOD  = 5'd1;
   localparam logic [4:0] EXC_TLBL = 5'd2;
   localparam logic [4:0] EXC_TLBS = 5'd3;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_CPU  = 5'd11;
   localparam logic [4:0] EXC_OV   = 5'd12;
   localparam logic [4:0] EXC_TR   = 5'd13;

endpackage

module except_ctrl
   import except_ctrl_pkg::*;
#(
   parameter int          HW_INT_LINES   = 6,
   parameter int          SYNC_STAGES    = 2,
   parameter int          HOLDOFF_CYCLES = 2,
   parameter logic [31:0] BEV_BASE       = 32'hbfc00200
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [HW_INT_LINES-1:0] hw_int,
   input  logic                    timer_tick,
   input  logic                    compare_wr,
   input  logic                    inst_valid,
   input  logic                    stall,
   input  logic [31:0]             pc,
   input  logic                    delayslot,
   input  Except_info_t            except,
   input  logic                    is_user_mode,
   input  logic                    mem_we,
   input  logic [31:0]             data_vaddr,
   input  CP0_regs_t               cp0_regs,
   output Except_request_t         except_req,
   output logic [7:0]              int_pending
);

   localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLUSH,
      S_HOLD
   } state_t;

   state_t                                 state, state_nxt;
   logic [CNT_W-1:0]                       cnt, cnt_nxt;
   logic [SYNC_STAGES-1:0][HW_INT_LINES-1:0] sync_q;
   logic                                   timer_pend;
   logic [7:0]                             ip_vec;
   logic [7:0]                             ip_masked;
   Except_info_t                           exc_q;
   logic                                   int_take;
   logic                                   exc_any;
   logic                                   accept;
   logic [4:0]                             sel_code;
   logic [31:0]                            sel_extra;
   logic                                   sel_eret;
   logic                                   sel_refill;
   logic [11:0]                            vec_off;
   logic [31:0]                            jump_pc;
   Except_request_t                        req_d, req_q;
   logic                                   unused_bits;

   assign unused_bits = ^{cp0_regs.cause.ip[7:2], cp0_regs.ebase[11:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], hw_int};
      end
   end

   // A Compare write in the same cycle as the tick wins, so the tick is lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_pend <= 1'b0;
      end else if (compare_wr) begin
         timer_pend <= 1'b0;
      end else if (timer_tick) begin
         timer_pend <= 1'b1;
      end
   end

   always_comb begin
      ip_vec                      = '0;
      ip_vec[1:0]                 = cp0_regs.cause.ip[1:0];
      ip_vec[2 +: HW_INT_LINES]   = sync_q[SYNC_STAGES-1];
      ip_vec[7]                   = ip_vec[7] | timer_pend;
   end

   assign int_pending = ip_vec;
   assign ip_masked   = ip_vec & cp0_regs.status.im;

   always_comb begin
      exc_q           = except;
      exc_q.priv_inst = except.priv_inst & is_user_mode;
   end

   assign int_take = cp0_regs.status.ie & ~cp0_regs.status.exl & ~cp0_regs.status.erl &
                     (|ip_masked) & inst_valid;
   assign exc_any  = int_take | (|exc_q);
   assign accept   = exc_any & ~stall & (state == S_IDLE);

   // Priority resolution; a privileged instruction in user mode is reported as CpU.
   always_comb begin
      sel_code   = EXC_INT;
      sel_extra  = '0;
      sel_eret   = 1'b0;
      sel_refill = 1'b0;
      if (int_take) begin
         sel_code  = EXC_INT;
         sel_extra = {24'h0, ip_masked};
      end else if (exc_q.inst_adel) begin
         sel_code  = EXC_ADEL;
         sel_extra = pc;
      end else if (exc_q.inst_tlb_miss | exc_q.inst_tlb_invalid) begin
         sel_code   = EXC_TLBL;
         sel_extra  = pc;
         sel_refill = exc_q.inst_tlb_miss;
      end else if (exc_q.syscall) begin
         sel_code = EXC_SYS;
      end else if (exc_q.brk) begin
         sel_code = EXC_BP;
      end else if (exc_q.overflow) begin
         sel_code = EXC_OV;
      end else if (exc_q.trap) begin
         sel_code = EXC_TR;
      end else if (exc_q.eret) begin
         sel_eret = 1'b1;
      end else if (exc_q.cpu | exc_q.priv_inst) begin
         sel_code  = EXC_CPU;
         sel_extra = 32'd1;
      end else if (exc_q.ri) begin
         sel_code = EXC_RI;
      end else if (exc_q.data_adel) begin
         sel_code  = mem_we ? EXC_ADES : EXC_ADEL;
         sel_extra = data_vaddr;
      end else if (exc_q.data_tlb_miss | exc_q.data_addr_invalid) begin
         sel_code   = mem_we ? EXC_TLBS : EXC_TLBL;
         sel_extra  = data_vaddr;
         sel_refill = exc_q.data_tlb_miss;
      end else if (exc_q.data_mod) begin
         sel_code  = EXC_MOD;
         sel_extra = data_vaddr;
      end
   end

   // Refill vector only on the first-level miss; nested misses go through the general vector.
   always_comb begin
      if (sel_refill & ~cp0_regs.status.exl) begin
         vec_off = 12'h000;
      end else if (int_take & cp0_regs.cause.iv & ~cp0_regs.status.exl) begin
         vec_off = 12'h200;
      end else begin
         vec_off = 12'h180;
      end
   end

   always_comb begin
      if (sel_eret) begin
         jump_pc = cp0_regs.status.erl ? cp0_regs.error_epc : cp0_regs.epc;
      end else if (cp0_regs.status.bev) begin
         jump_pc = BEV_BASE + {20'h0, vec_off};
      end else begin
         jump_pc = {cp0_regs.ebase[31:12], vec_off};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            state_nxt = S_HOLD;
            cnt_nxt   = CNT_W'(HOLDOFF_CYCLES - 1);
         end
         S_HOLD: begin
            if (cnt == '0) begin
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // The request is loaded only on accept, so it self-clears after its single FLUSH cycle.
   always_comb begin
      req_d = '0;
      if (accept) begin
         req_d.flush      = 1'b1;
         req_d.code       = sel_code;
         req_d.eret       = sel_eret;
         req_d.delayslot  = delayslot;
         req_d.current_pc = pc;
         req_d.jump_pc    = jump_pc;
         req_d.extra      = sel_extra;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q <= '0;
      end else begin
         req_q <= req_d;
      end
   end

   assign except_req = req_q;

endmodule
